ahb_sram_responder: RTL and testbench

- AHB-Lite subordinate (responder) that serves single NONSEQ/SEQ transfers from bus initiators such as instruction fetch and the load/store unit.
- Wraps a word-organised SRAM array.
- Supports byte, halfword and word accesses, optional wait states, and the two-cycle ERROR response.
- Sits behind the bus decoder/mux; hready is the mux's combined ready.

---
 rtl/ahb_sram_responder_if.sv | 24 ++
 rtl/ahb_sram_responder.sv | 145 ++++++++++++++
 tb/tb_ahb_sram_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_responder_if.sv
// AHB-Lite bus bundle between an initiator/decoder and the SRAM responder.
// Carries address/control, write data, ready and response signals.
interface ahb_sram_responder_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: byte/half/word access, two-cycle ERROR,
// read-after-write byte-lane bypass, optional wait states.
// Ports: clock, reset (async, active-low), bus (slave modport).
// Optional feature macro: RESPONDER_WAIT_STATES_EN (WAIT_CYCLES waits).
module ahb_sram_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic                  clock,
    input logic                  reset,
    ahb_sram_responder_if.slave  bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCESS = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] ERR1   = 3'd3;
    localparam logic [2:0] ERR2   = 3'd4;

`ifdef RESPONDER_WAIT_STATES_EN
    localparam bit WAITS_ON = 1'b1;
`else
    localparam bit WAITS_ON = 1'b0;
`endif

    logic [2:0]    state;
    logic [2:0]    next;
    logic [2:0]    start;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [2:0]    size_q;
    logic          wr_q;
    logic [31:0]   rd_q;
    logic [31:0]   fwd;
    logic [31:0]   mem [DEPTH];

    logic          ready_now;
    logic          accept;
    logic          bad;
    logic          go_wait;
    logic          do_write;
    logic [AW-1:0] idx;
    logic [3:0]    wmask;
    logic          unused_trans;

    function automatic logic [3:0] lanes(input logic [2:0] size,
                                         input logic [1:0] off);
        case (size)
            3'd0:    lanes = 4'b0001 << off;
            3'd1:    lanes = off[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    assign unused_trans = bus.htrans[0];
    assign ready_now = (state != WAIT) && (state != ERR1);
    // Only take a new address phase while our own data phase can end.
    assign accept = bus.hsel && bus.hready && bus.htrans[1] && ready_now;
    assign idx = bus.haddr[AW+1:2];
    assign bad = ({1'b0, bus.haddr} >= LIMIT)
              || (bus.hsize > 3'd2)
              || ((bus.hsize == 3'd1) && bus.haddr[0])
              || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
    assign go_wait = WAITS_ON && (WAIT_CYCLES != 0);
    assign start = bad ? ERR1 : (go_wait ? WAIT : ACCESS);
    assign wmask = lanes(size_q, off_q);
    assign do_write = (state == ACCESS) && wr_q && bus.hready;

`ifdef RESPONDER_WAIT_STATES_EN
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    logic [CW-1:0] cnt;
    logic          wait_done;

    assign wait_done = (cnt <= CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept && !bad && go_wait) begin
            cnt <= CW'(WAIT_CYCLES);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end
`else
    logic wait_done;
    assign wait_done = 1'b1;
`endif

    always_comb begin
        next = state;
        unique case (state)
            IDLE:         if (accept) next = start;
            ACCESS, ERR2: if (bus.hready) next = accept ? start : IDLE;
            WAIT:         if (wait_done) next = ACCESS;
            ERR1:         next = ERR2;
            default:      next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx_q  <= '0;
            off_q  <= '0;
            size_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                idx_q  <= idx;
                off_q  <= bus.haddr[1:0];
                size_q <= bus.hsize;
                wr_q   <= bus.hwrite && !bad;
            end
        end
    end

    // Read issued at acceptance; merge lanes of a write finishing now.
    always_comb begin
        fwd = mem[idx];
        if (do_write && (idx_q == idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) fwd[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
        if (accept && !bad && !bus.hwrite) begin
            rd_q <= fwd;
        end
    end

    assign bus.hreadyout = ready_now;
    assign bus.hresp     = (state == ERR1) || (state == ERR2);
    assign bus.hrdata    = ((state == ACCESS) && !wr_q) ? rd_q : 32'd0;
endmodule

// File: tb/tb_ahb_sram_responder.sv
// Self-checking bench for ahb_sram_responder: directed table,
// back-to-back bypass, reset/stall sequences, randomized traffic.
module tb_ahb_sram_responder;
    localparam int DEPTH = 1024;
`ifdef RESPONDER_WAIT_STATES_EN
    localparam int WC = 2;
`else
    localparam int WC = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mm [DEPTH*4];

    always #5 clock = ~clock;

    ahb_sram_responder_if bus();
    assign bus.hready = bus.hreadyout & ~stall;

    ahb_sram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_bad;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] a, logic w, logic [2:0] s,
                                logic [31:0] d, logic eb, logic [31:0] er);
        vec_t v;
        v.addr = a; v.wr = w; v.size = s;
        v.wdata = d; v.exp_bad = eb; v.exp_rd = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a, input logic [2:0] s);
        if (a >= 32'(DEPTH*4)) return 1'b1;
        if (s > 3'd2) return 1'b1;
        return (a & ((32'd1 << s) - 32'd1)) != 32'd0;
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [2:0] s,
                                        input logic [31:0] d);
        for (int k = 0; k < (1 << s); k++) begin
            int b;
            b = int'(a) + k;
            mm[b] = d[8*(b%4) +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int b;
        b = int'(a) & ~3;
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    task automatic go_idle();
        bus.hsel = 1'b0;
        bus.htrans = 2'd0;
        bus.hwrite = 1'b0;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w,
                              input logic [2:0] s);
        bus.hsel = 1'b1;
        bus.haddr = a;
        bus.htrans = 2'd2;
        bus.hwrite = w;
        bus.hsize = s;
    endtask

    task automatic wait_ready(input string nm);
        int lows;
        lows = 0;
        @(negedge clock);
        while (!bus.hreadyout && lows < 20) begin
            lows++;
            @(negedge clock);
        end
        chk({nm, "_waits"}, 32'(lows), 32'(WC));
    endtask

    task automatic xfer(input string nm, input logic [31:0] a,
                        input logic w, input logic [2:0] s,
                        input logic [31:0] d, input logic eb,
                        input logic [31:0] er);
        @(negedge clock);
        drive_addr(a, w, s);
        bus.hwdata = 32'd0;
        @(posedge clock);
        #1;
        go_idle();
        bus.hwdata = d;
        if (eb) begin
            @(negedge clock);
            chk({nm, "_err1"}, {30'd0, bus.hreadyout, bus.hresp}, 32'd1);
            chk({nm, "_err1_rd"}, bus.hrdata, 32'd0);
            @(negedge clock);
            chk({nm, "_err2"}, {30'd0, bus.hreadyout, bus.hresp}, 32'd3);
            @(posedge clock);
        end else begin
            wait_ready(nm);
            chk({nm, "_resp"}, {31'd0, bus.hresp}, 32'd0);
            if (!w) chk({nm, "_data"}, bus.hrdata, er);
            @(posedge clock);
            if (w) model_write(a, s, d);
        end
    endtask

    task automatic b2b(input string nm, input logic [31:0] wa,
                       input logic [2:0] ws, input logic [31:0] wd,
                       input logic [31:0] ra, input logic [2:0] rs);
        @(negedge clock);
        drive_addr(wa, 1'b1, ws);
        @(posedge clock);
        #1;
        bus.hwdata = wd;
        drive_addr(ra, 1'b0, rs);
        wait_ready({nm, "_w"});
        chk({nm, "_wresp"}, {31'd0, bus.hresp}, 32'd0);
        @(posedge clock);
        #1;
        go_idle();
        model_write(wa, ws, wd);
        wait_ready({nm, "_r"});
        chk({nm, "_rresp"}, {31'd0, bus.hresp}, 32'd0);
        chk({nm, "_rdata"}, bus.hrdata, model_read(ra));
        @(posedge clock);
    endtask

    initial begin
        bus.haddr = 32'd0;
        bus.hsize = 3'd2;
        bus.hwdata = 32'd0;
        go_idle();

        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, bus.hreadyout}, 32'd1);
        chk("rst_resp", {31'd0, bus.hresp}, 32'd0);
        chk("rst_rdata", bus.hrdata, 32'd0);
        reset = 1'b1;

        tbl.push_back(mk(32'h0,    1, 2, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(32'h10,   1, 2, 32'h11223344, 0, 0));
        tbl.push_back(mk(32'h13,   1, 0, 32'hAA000000, 0, 0));
        tbl.push_back(mk(32'h10,   0, 2, 0, 0, 32'hAA223344));
        tbl.push_back(mk(32'h4002, 0, 2, 0, 1, 0));
        tbl.push_back(mk(32'h0,    0, 2, 0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(32'h1000, 0, 2, 0, 1, 0));
        tbl.push_back(mk(32'h1000, 1, 2, 32'hFFFFFFFF, 1, 0));
        tbl.push_back(mk(32'h0,    0, 2, 0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(32'h20,   1, 2, 32'h12345678, 0, 0));
        tbl.push_back(mk(32'h22,   1, 1, 32'hBEEF0000, 0, 0));
        tbl.push_back(mk(32'h21,   0, 0, 0, 0, 32'hBEEF5678));
        tbl.push_back(mk(32'h1,    0, 1, 0, 1, 0));
        tbl.push_back(mk(32'h2,    0, 2, 0, 1, 0));
        tbl.push_back(mk(32'h0,    0, 3, 0, 1, 0));
        tbl.push_back(mk(32'h20,   1, 2, 32'h12345678, 0, 0));
        tbl.push_back(mk(32'h20,   0, 2, 0, 0, 32'h12345678));
        tbl.push_back(mk(32'hFFC,  1, 2, 32'h0BADF00D, 0, 0));
        tbl.push_back(mk(32'hFFE,  0, 1, 0, 0, 32'h0BADF00D));
        tbl.push_back(mk(32'h0,    0, 2, 0, 0, 32'hCAFEF00D));

        foreach (tbl[i]) begin
            xfer($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr,
                 tbl[i].size, tbl[i].wdata, tbl[i].exp_bad,
                 tbl[i].exp_rd);
        end

        b2b("raw_word", 32'h10, 3'd2, 32'hDEADBEEF, 32'h10, 3'd2);
        chk("raw_word_const", model_read(32'h10), 32'hDEADBEEF);
        b2b("raw_byte", 32'h12, 3'd0, 32'h00550000, 32'h10, 3'd2);
        b2b("raw_other", 32'h14, 3'd2, 32'h01020304, 32'h10, 3'd2);

        // Reset while in the first ERROR cycle.
        @(negedge clock);
        drive_addr(32'h4002, 1'b0, 3'd2);
        @(posedge clock);
        #1;
        go_idle();
        @(negedge clock);
        chk("mid_err1", {30'd0, bus.hreadyout, bus.hresp}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_hs", {30'd0, bus.hreadyout, bus.hresp}, 32'd2);
        chk("mid_rst_rd", bus.hrdata, 32'd0);
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_idle", {30'd0, bus.hreadyout, bus.hresp}, 32'd2);
        xfer("post_rst_rd", 32'h0, 1'b0, 3'd2, 0, 1'b0, model_read(32'h0));

        // Another responder stalls the bus: no access must occur.
        @(negedge clock);
        stall = 1'b1;
        drive_addr(32'h0, 1'b1, 3'd2);
        bus.hwdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clock);
        chk("stall_ready", {31'd0, bus.hreadyout}, 32'd1);
        go_idle();
        stall = 1'b0;
        xfer("stall_rd", 32'h0, 1'b0, 3'd2, 0, 1'b0, 32'hCAFEF00D);

        for (int w = 0; w < 16; w++) begin
            xfer("init", 32'(w*4), 1'b1, 3'd2, $urandom, 1'b0, 0);
        end

        for (int n = 0; n < 150; n++) begin
            int mode;
            logic [31:0] a;
            logic [2:0] s;
            logic w;
            logic eb;
            mode = $urandom_range(0, 9);
            if (mode < 3) begin
                logic [31:0] ra;
                logic [2:0] rs;
                s = 3'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 63)) & ~((32'd1 << s) - 32'd1);
                rs = 3'($urandom_range(0, 2));
                ra = 32'($urandom_range(0, 63)) & ~((32'd1 << rs) - 32'd1);
                b2b("rnd_b2b", a, s, $urandom, ra, rs);
            end else begin
                s = 3'($urandom_range(0, 3));
                if (mode == 9) a = 32'h1000 + 32'($urandom_range(0, 4095));
                else a = 32'($urandom_range(0, 63));
                w = 1'($urandom_range(0, 1));
                eb = is_bad(a, s);
                xfer("rnd", a, w, s, $urandom, eb,
                     eb ? 32'd0 : model_read(a));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
